// File: rtl/pdm_mic_ctrl.sv
// Stereo PDM microphone controller: PDM clock generation, L/R demux, CIC decimator sequencing,
// warm-up discard and a two-entry left-priority PCM output stream. Optional macro: PDM_MIC_CTRL_OVERRUN_CNT_EN.
module pdm_mic_ctrl #(
  parameter int CLK_DIV        = 4,
  parameter int STARTUP_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               pdm_clk,
  input  logic               pdm_data,
  output logic               dec_clr,
  output logic               dec_ce,
  output logic               dec_l_bit,
  output logic               dec_r_bit,
  input  logic signed [15:0] pcm_l,
  input  logic signed [15:0] pcm_r,
  input  logic               pcm_l_valid,
  input  logic               pcm_r_valid,
  output logic signed [15:0] out_data,
  output logic               out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         overrun_count
);

  typedef enum logic [1:0] {IDLE, WAKE, RUN, STOP} state_e;

  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [15:0] FRAMES_INIT = 16'(STARTUP_FRAMES);

  state_e             state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [15:0]        frame_q, frame_d;
  logic               pdm_clk_q, pdm_clk_d;
  logic               l_bit_q, r_bit_q, dec_ce_q, dec_clr_q;
  logic signed [15:0] hold_l_q, hold_r_q;
  logic               full_l_q, full_r_q, full_l_d, full_r_d;
  logic               overrun_q, overrun_d;
  logic               running, tc, start, stop_done;
  logic               accept, acc_l, acc_r, cap_l, cap_r, ov_l, ov_r;

  assign running   = (state_q != IDLE);
  assign tc        = running && (div_q == DIV_LAST);
  assign stop_done = (state_q == STOP) && tc && !pdm_clk_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d = WAKE;
        frame_d = FRAMES_INIT;
        start   = 1'b1;
      end
      WAKE: begin
        if (!enable)                           state_d = STOP;
        else if (frame_q == 16'd0)             state_d = RUN;
        else if (pcm_l_valid && pcm_r_valid)   frame_d = frame_q - 16'd1;
      end
      RUN:  if (!enable) state_d = STOP;
      STOP: if (stop_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last toggle in STOP is suppressed so the clock parks low after its final low half.
  always_comb begin
    div_d     = (!running || tc) ? 8'd0 : div_q + 8'd1;
    pdm_clk_d = pdm_clk_q;
    if (!running)                pdm_clk_d = 1'b0;
    else if (tc && !stop_done)   pdm_clk_d = ~pdm_clk_q;
  end

  assign accept = full_l_q || full_r_q ? out_ready : 1'b0;
  assign acc_l  = accept && full_l_q;
  assign acc_r  = accept && !full_l_q && full_r_q;
  assign cap_l  = (state_q == RUN) && pcm_l_valid && !full_l_q;
  assign cap_r  = (state_q == RUN) && pcm_r_valid && !full_r_q;
  assign ov_l   = (state_q == RUN) && pcm_l_valid && full_l_q;
  assign ov_r   = (state_q == RUN) && pcm_r_valid && full_r_q;

  always_comb begin
    full_l_d  = cap_l || (full_l_q && !acc_l);
    full_r_d  = cap_r || (full_r_q && !acc_r);
    overrun_d = start ? 1'b0 : (overrun_q || ov_l || ov_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= 8'd0;
      frame_q   <= 16'd0;
      pdm_clk_q <= 1'b0;
      l_bit_q   <= 1'b0;
      r_bit_q   <= 1'b0;
      dec_ce_q  <= 1'b0;
      dec_clr_q <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      full_l_q  <= 1'b0;
      full_r_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      frame_q   <= frame_d;
      pdm_clk_q <= pdm_clk_d;
      if (tc && pdm_clk_q)  l_bit_q <= pdm_data;
      if (tc && !pdm_clk_q) r_bit_q <= pdm_data;
      dec_ce_q  <= tc && !pdm_clk_q;
      dec_clr_q <= start;
      if (cap_l) hold_l_q <= pcm_l;
      if (cap_r) hold_r_q <= pcm_r;
      full_l_q  <= full_l_d;
      full_r_q  <= full_r_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PDM_MIC_CTRL_OVERRUN_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_sum;

  // Both channels can drop a sample in the same cycle, so the step can be 2.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 9'(ov_l) + 9'(ov_r);
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign overrun_count = cnt_q;
`else
  assign overrun_count = 8'd0;
`endif

  assign pdm_clk   = pdm_clk_q;
  assign dec_clr   = dec_clr_q;
  assign dec_ce    = dec_ce_q;
  assign dec_l_bit = l_bit_q;
  assign dec_r_bit = r_bit_q;
  assign out_valid = full_l_q || full_r_q;
  assign out_data  = full_l_q ? hold_l_q : hold_r_q;
  assign out_ch    = !full_l_q && full_r_q;
  assign busy      = running;
  assign overrun   = overrun_q;

endmodule
